// File: rtl/register_16.sv
// 16-bit state register with write enable and an
// asynchronous reset that loads a caller-supplied value.
module register_16 (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] initialdata,
  input  logic [15:0] d,
  input  logic        RegWrite,
  output logic [15:0] r
);

  // Reset loads initialdata, which the system holds stable while reset is high
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r <= initialdata;
    end else if (RegWrite) begin
      r <= d;
    end
  end

endmodule

// File: tb/tb_register_16.sv
// Directed self-checking bench for register_16.
module tb_register_16;

  logic        CLK;
  logic        reset;
  logic [15:0] initialdata;
  logic [15:0] d;
  logic        RegWrite;
  logic [15:0] r;

  int checks;
  int errors;

  register_16 dut (
    .CLK(CLK),
    .reset(reset),
    .initialdata(initialdata),
    .d(d),
    .RegWrite(RegWrite),
    .r(r)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (r !== 16'd10) begin
      errors++;
      $display("FAIL reset_hold: r=%h expected=%h", r, 16'd10);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge CLK);
    d = 16'd1;
    RegWrite = 1'b1;
    tick();
    checks++;
    if (r !== 16'd10) begin
      errors++;
      $display("FAIL reset_priority: r=%h expected=%h", r, 16'd10);
    end
  endtask

  task automatic test_first_write();
    @(negedge CLK);
    reset = 1'b0;
    #1;
    checks++;
    if (r !== 16'd10) begin
      errors++;
      $display("FAIL release_hold: r=%h expected=%h", r, 16'd10);
    end
    tick();
    checks++;
    if (r !== 16'd1) begin
      errors++;
      $display("FAIL first_write: r=%h expected=%h", r, 16'd1);
    end
  endtask

  task automatic test_hold();
    @(negedge CLK);
    RegWrite = 1'b0;
    d = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (r !== 16'd1) begin
        errors++;
        $display("FAIL hold_%0d: r=%h expected=%h", i, r, 16'd1);
      end
    end
  endtask

  task automatic test_full_width();
    @(negedge CLK);
    RegWrite = 1'b1;
    d = 16'hFFFF;
    #1;
    checks++;
    if (r !== 16'd1) begin
      errors++;
      $display("FAIL no_comb_path: r=%h expected=%h", r, 16'd1);
    end
    tick();
    checks++;
    if (r !== 16'hFFFF) begin
      errors++;
      $display("FAIL write_ones: r=%h expected=%h", r, 16'hFFFF);
    end
    @(negedge CLK);
    d = 16'h0000;
    tick();
    checks++;
    if (r !== 16'h0000) begin
      errors++;
      $display("FAIL write_zeros: r=%h expected=%h", r, 16'h0000);
    end
    @(negedge CLK);
    d = 16'hFFFF;
    tick();
    checks++;
    if (r !== 16'hFFFF) begin
      errors++;
      $display("FAIL rewrite_ones: r=%h expected=%h", r, 16'hFFFF);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    initialdata = 16'h00A5;
    d = 16'hBEEF;
    RegWrite = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (r !== 16'h00A5) begin
      errors++;
      $display("FAIL async_reset: r=%h expected=%h", r, 16'h00A5);
    end
    tick();
    checks++;
    if (r !== 16'h00A5) begin
      errors++;
      $display("FAIL pending_discard: r=%h expected=%h", r, 16'h00A5);
    end
  endtask

  task automatic test_release_write();
    @(negedge CLK);
    reset = 1'b0;
    d = 16'h1234;
    RegWrite = 1'b1;
    #1;
    checks++;
    if (r !== 16'h00A5) begin
      errors++;
      $display("FAIL release_pre_edge: r=%h expected=%h", r, 16'h00A5);
    end
    tick();
    checks++;
    if (r !== 16'h1234) begin
      errors++;
      $display("FAIL release_write: r=%h expected=%h", r, 16'h1234);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    RegWrite = 1'b1;
    d = 16'hA5A5;
    tick();
    checks++;
    if (r !== 16'hA5A5) begin
      errors++;
      $display("FAIL b2b_0: r=%h expected=%h", r, 16'hA5A5);
    end
    @(negedge CLK);
    d = 16'h5A5A;
    tick();
    checks++;
    if (r !== 16'h5A5A) begin
      errors++;
      $display("FAIL b2b_1: r=%h expected=%h", r, 16'h5A5A);
    end
    @(negedge CLK);
    RegWrite = 1'b0;
    d = 16'h0F0F;
    tick();
    checks++;
    if (r !== 16'h5A5A) begin
      errors++;
      $display("FAIL b2b_hold: r=%h expected=%h", r, 16'h5A5A);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    initialdata = 16'd10;
    d = 16'd0;
    RegWrite = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (r !== 16'd10) begin
      errors++;
      $display("FAIL reset_immediate: r=%h expected=%h", r, 16'd10);
    end
    test_reset();
    test_reset_priority();
    test_first_write();
    test_hold();
    test_full_width();
    test_async_reset();
    test_release_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
